gate_response_checker: RTL

Hardware response checker for the two-input logic gates in the Day-1 gate library: the receiving end of the stimulus a gate bench applies. It samples each applied input pair `{a,b}` together with the gate output `y`, compares `y` against a parameterised truth table, and counts vectors and mismatches. It tracks which of the four input combinations have been exercised and reports pass/fail once all four are covered. It sits beside any gate instance, such as the NAND gate, and turns a stimulus sequence into a self-checking result.

---
 rtl/gate_response_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/gate_response_checker.sv
// Two-input gate response checker: compares sampled {a,b,y} against TRUTH, counts vectors/errors, tracks coverage.
// Optional feature macro GATE_CHK_STOP_ON_FAIL_EN: end the run at the first mismatch.
module gate_response_checker #(
    parameter logic [3:0] TRUTH = 4'b0111,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [1:0]       first_err_vec,
    output logic             first_err_valid
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic             vld_p1, vld_p1_d;
    logic             a_p1, b_p1, y_p1;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       cov_q, cov_d;
    logic [1:0]       fev_q, fev_d;
    logic             fevld_q, fevld_d;
    logic             pass_q, pass_d;
    logic [1:0]       idx;
    logic             mis;
    logic             fin;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    assign idx = {a_p1, b_p1};
    assign mis = (y_p1 != TRUTH[idx]);

    // Stage 1: vector capture; only sampled while checking, and never alongside start
    assign vld_p1_d = (state_q == CHECK) && vec_valid && !start;

    always_ff @(posedge clk) begin
        a_p1 <= a;
        b_p1 <= b;
        y_p1 <= y;
    end

    // Stage 2: compare, count and coverage update
    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        cov_d     = cov_q;
        fev_d     = fev_q;
        fevld_d   = fevld_q;
        pass_d    = pass_q;
        fin       = 1'b0;
        if (start) begin
            state_d   = CHECK;
            vec_cnt_d = '0;
            err_cnt_d = '0;
            cov_d     = 4'h0;
            fev_d     = 2'b00;
            fevld_d   = 1'b0;
            pass_d    = 1'b0;
        end else if (state_q == CHECK && vld_p1) begin
            cov_d     = cov_q | (4'b0001 << idx);
            vec_cnt_d = sat_inc(vec_cnt_q);
            if (mis) begin
                err_cnt_d = sat_inc(err_cnt_q);
                if (!fevld_q) begin
                    fev_d   = idx;
                    fevld_d = 1'b1;
                end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                fin = 1'b1;
`endif
            end
            if (cov_d == 4'hF) fin = 1'b1;
            if (fin) begin
                state_d = DONE;
                pass_d  = (err_cnt_d == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vld_p1    <= 1'b0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            cov_q     <= 4'h0;
            fev_q     <= 2'b00;
            fevld_q   <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_p1    <= vld_p1_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            cov_q     <= cov_d;
            fev_q     <= fev_d;
            fevld_q   <= fevld_d;
            pass_q    <= pass_d;
        end
    end

    assign busy            = (state_q == CHECK);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign vec_cnt         = vec_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign cov             = cov_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevld_q;

endmodule
